// File: rtl/minmax_reduce_stream_if.sv
// Stream bus for the min/max reduction unit: a word stream in, one result out.
// The master side is the frame source plus the result sink; the slave side is the reducer.
interface minmax_reduce_stream_if #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
);
    logic                 mode;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_data;
    logic [CNT_WIDTH-1:0] out_index;
    logic [CNT_WIDTH-1:0] out_count;
    logic                 out_ovf;

    modport master (
        output mode, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_index, out_count, out_ovf
    );

    modport slave (
        input  mode, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_index, out_count, out_ovf
    );
endinterface

// File: rtl/minmax_reduce_stream.sv
// Streaming min/max reduction. One comparator, one word per cycle.
// A frame is folded into a running accumulator; on the last word the
// final value, its position and the frame length are held until taken.
module minmax_reduce_stream #(
    parameter int WIDTH     = 8,
    parameter int SIGNED    = 0,
    parameter int CNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    minmax_reduce_stream_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0]     data;
        logic [CNT_WIDTH-1:0] idx;
        logic [CNT_WIDTH-1:0] cnt;
        logic                 ovf;
    } result_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    // Two's-complement order maps onto unsigned order by flipping the sign bit.
    function automatic logic [WIDTH-1:0] cmp_key(input logic [WIDTH-1:0] v);
        if (SIGNED != 0) return v ^ {1'b1, {(WIDTH-1){1'b0}}};
        else             return v;
    endfunction

    state_t           state;
    logic             rdy_q;
    logic             vld_q;
    logic             mode_q;
    result_t          acc_q;
    result_t          acc_nxt;
    result_t          res_q;
    logic             beat;
    logic             better;
    logic [WIDTH-1:0] key_in;
    logic [WIDTH-1:0] key_acc;

    // rdy_q mirrors the state (low only in HOLD) but is a register so it
    // also reads low through reset and the cycle that follows it.
    assign beat    = bus.in_valid & rdy_q;
    assign key_in  = cmp_key(bus.in_data);
    assign key_acc = cmp_key(acc_q.data);
    // Strict compare: ties keep the earlier element.
    assign better  = mode_q ? (key_in > key_acc) : (key_in < key_acc);

    // Next accumulator value for a beat accepted this cycle.
    always_comb begin
        acc_nxt = acc_q;
        if (state == IDLE) begin
            acc_nxt.data = bus.in_data;
            acc_nxt.idx  = '0;
            acc_nxt.cnt  = CNT_ONE;
            acc_nxt.ovf  = 1'b0;
        end else begin
            if (better) begin
                acc_nxt.data = bus.in_data;
                // cnt is this beat's position, already clamped once saturated.
                acc_nxt.idx  = acc_q.cnt;
            end
            if (acc_q.cnt == CNT_MAX) acc_nxt.ovf = 1'b1;
            else                      acc_nxt.cnt = acc_q.cnt + 1'b1;
        end
    end

    // Frame FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rdy_q  <= 1'b0;
            vld_q  <= 1'b0;
            mode_q <= 1'b0;
            acc_q  <= '0;
            res_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    rdy_q <= 1'b1;
                    if (beat) begin
                        acc_q  <= acc_nxt;
                        mode_q <= bus.mode;
                        if (bus.in_last) begin
                            res_q <= acc_nxt;
                            vld_q <= 1'b1;
                            rdy_q <= 1'b0;
                            state <= HOLD;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        acc_q <= acc_nxt;
                        if (bus.in_last) begin
                            res_q <= acc_nxt;
                            vld_q <= 1'b1;
                            rdy_q <= 1'b0;
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        vld_q <= 1'b0;
                        rdy_q <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    vld_q <= 1'b0;
                    rdy_q <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = rdy_q;
    assign bus.out_valid = vld_q;
    assign bus.out_data  = res_q.data;
    assign bus.out_index = res_q.idx;
    assign bus.out_count = res_q.cnt;
    assign bus.out_ovf   = res_q.ovf;

endmodule

// File: tb/tb_minmax_reduce_stream.sv
// Bench for minmax_reduce_stream: three instances (unsigned, signed, 2-bit
// counter) share one stimulus stream; a frame-level model predicts each result.
module tb_minmax_reduce_stream;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mode = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] in_data = 8'h00;

    always #5 clk = ~clk;

    minmax_reduce_stream_if #(.WIDTH(8), .CNT_WIDTH(16)) bu ();
    minmax_reduce_stream_if #(.WIDTH(8), .CNT_WIDTH(16)) bs ();
    minmax_reduce_stream_if #(.WIDTH(8), .CNT_WIDTH(2))  bo ();

    assign bu.mode = mode; assign bu.in_valid = in_valid; assign bu.in_data = in_data;
    assign bu.in_last = in_last; assign bu.out_ready = out_ready;
    assign bs.mode = mode; assign bs.in_valid = in_valid; assign bs.in_data = in_data;
    assign bs.in_last = in_last; assign bs.out_ready = out_ready;
    assign bo.mode = mode; assign bo.in_valid = in_valid; assign bo.in_data = in_data;
    assign bo.in_last = in_last; assign bo.out_ready = out_ready;

    minmax_reduce_stream #(.WIDTH(8), .SIGNED(0), .CNT_WIDTH(16)) dut_u (.clk(clk), .rst(rst), .bus(bu.slave));
    minmax_reduce_stream #(.WIDTH(8), .SIGNED(1), .CNT_WIDTH(16)) dut_s (.clk(clk), .rst(rst), .bus(bs.slave));
    minmax_reduce_stream #(.WIDTH(8), .SIGNED(0), .CNT_WIDTH(2))  dut_o (.clk(clk), .rst(rst), .bus(bo.slave));

    logic        o_rdy [3];
    logic        o_vld [3];
    logic        o_ovf [3];
    logic [7:0]  o_data[3];
    logic [15:0] o_idx [3];
    logic [15:0] o_cnt [3];

    assign o_rdy[0] = bu.in_ready; assign o_vld[0] = bu.out_valid; assign o_ovf[0] = bu.out_ovf;
    assign o_data[0] = bu.out_data; assign o_idx[0] = bu.out_index; assign o_cnt[0] = bu.out_count;
    assign o_rdy[1] = bs.in_ready; assign o_vld[1] = bs.out_valid; assign o_ovf[1] = bs.out_ovf;
    assign o_data[1] = bs.out_data; assign o_idx[1] = bs.out_index; assign o_cnt[1] = bs.out_count;
    assign o_rdy[2] = bo.in_ready; assign o_vld[2] = bo.out_valid; assign o_ovf[2] = bo.out_ovf;
    assign o_data[2] = bo.out_data; assign o_idx[2] = {14'b0, bo.out_index}; assign o_cnt[2] = {14'b0, bo.out_count};

    int unsigned total = 0;
    int unsigned bad   = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // ---------------- frame-level model ----------------
    const int SGN[3] = '{0, 1, 0};
    const int CWD[3] = '{16, 16, 2};

    int          frame[$];
    bit          frame_mode = 1'b0;
    bit          have_res   = 1'b0;
    bit          settle     = 1'b1;   // last edge was a reset edge
    logic [7:0]  e_data[3];
    logic [15:0] e_idx [3];
    logic [15:0] e_cnt [3];
    logic        e_ovf [3];

    function automatic int order_key(input int v, input int sgn);
        return (sgn != 0) ? (v ^ 8'h80) : v;
    endfunction

    // Whole-frame reduction: pick the first extreme element, clamp position and length.
    function automatic void reduce(input int d);
        int best = 0;
        int n    = frame.size();
        int mx   = (1 << CWD[d]) - 1;
        for (int i = 1; i < n; i++) begin
            int ki = order_key(frame[i], SGN[d]);
            int kb = order_key(frame[best], SGN[d]);
            if (frame_mode ? (ki > kb) : (ki < kb)) best = i;
        end
        e_data[d] = 8'(frame[best]);
        e_idx[d]  = 16'((best > mx) ? mx : best);
        e_cnt[d]  = 16'((n > mx) ? mx : n);
        e_ovf[d]  = (n > mx);
    endfunction

    // Check outputs left by the previous edge, then fold in what the next edge does.
    always @(negedge clk) begin
        bit rdy_exp;
        bit acc;
        rdy_exp = !have_res && !settle;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("in_ready[%0d]", d), o_rdy[d], rdy_exp);
            chk($sformatf("out_valid[%0d]", d), o_vld[d], have_res);
            if (settle) begin
                chk($sformatf("rst_data[%0d]", d), o_data[d], 0);
                chk($sformatf("rst_index[%0d]", d), o_idx[d], 0);
                chk($sformatf("rst_count[%0d]", d), o_cnt[d], 0);
                chk($sformatf("rst_ovf[%0d]", d), o_ovf[d], 0);
            end else if (have_res) begin
                chk($sformatf("out_data[%0d]", d), o_data[d], e_data[d]);
                chk($sformatf("out_index[%0d]", d), o_idx[d], e_idx[d]);
                chk($sformatf("out_count[%0d]", d), o_cnt[d], e_cnt[d]);
                chk($sformatf("out_ovf[%0d]", d), o_ovf[d], e_ovf[d]);
            end
        end
        if (rst) begin
            frame.delete();
            have_res = 1'b0;
            settle   = 1'b1;
        end else begin
            acc    = in_valid && rdy_exp;
            settle = 1'b0;
            if (have_res) begin
                if (out_ready) have_res = 1'b0;
            end else if (acc) begin
                if (frame.size() == 0) frame_mode = mode;
                frame.push_back(int'(in_data));
                if (in_last) begin
                    for (int d = 0; d < 3; d++) reduce(d);
                    have_res = 1'b1;
                    frame.delete();
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic beat(input logic [7:0] d, input bit l, input bit m);
        bit ok = 1'b0;
        in_valid = 1'b1; in_data = d; in_last = l; mode = m;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = bu.in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_last = 1'b0;
        in_data = 8'($urandom); mode = 1'($urandom);
        chk("beat_accept", ok, 1);
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            in_data = 8'($urandom); mode = 1'($urandom);
        end
    endtask

    // Returns at a falling edge where out_valid is high (or after the bound).
    task automatic wait_valid();
        bit ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = bu.out_valid;
        end
        chk("wait_out_valid", ok, 1);
    endtask

    task automatic release_out(input int hold);
        repeat (hold) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        int narrow;
        // reset held over two edges
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        gap(2);

        // unsigned min with a duplicate minimum
        beat(8'd200, 0, 0); beat(8'd17, 0, 0); beat(8'd99, 0, 0); beat(8'd17, 0, 0); beat(8'd255, 1, 0);
        @(negedge clk);
        chk("t1_latency_valid", bu.out_valid, 1);
        chk("t1_model_data", e_data[0], 17);
        chk("t1_data", bu.out_data, 17);
        chk("t1_index", bu.out_index, 1);
        chk("t1_count", bu.out_count, 5);
        release_out(0);

        // single-beat max frame held for a few cycles
        beat(8'h3C, 1, 1);
        @(negedge clk);
        chk("t2_ready_low", bu.in_ready, 0);
        chk("t2_data", bu.out_data, 8'h3C);
        chk("t2_index", bu.out_index, 0);
        chk("t2_count", bu.out_count, 1);
        release_out(3);

        // signed vs unsigned ordering, min then max
        beat(8'h05, 0, 0); beat(8'h80, 0, 0); beat(8'h7F, 0, 0); beat(8'hFF, 1, 0);
        wait_valid();
        chk("t3_smin_model", e_data[1], 8'h80);
        chk("t3_smin_data", bs.out_data, 8'h80);
        chk("t3_smin_index", bs.out_index, 1);
        chk("t3_umin_data", bu.out_data, 8'h05);
        release_out(1);
        beat(8'h05, 0, 1); beat(8'h80, 0, 1); beat(8'h7F, 0, 1); beat(8'hFF, 1, 1);
        wait_valid();
        chk("t3_smax_data", bs.out_data, 8'h7F);
        chk("t3_smax_index", bs.out_index, 2);
        chk("t3_umax_index", bu.out_index, 3);
        release_out(0);

        // backpressure: a waiting word must not be taken while the result is held
        beat(8'd1, 0, 0); beat(8'd2, 1, 0);
        wait_valid();
        in_valid = 1'b1; in_data = 8'h11; in_last = 1'b1; mode = 1'b0;
        release_out(10);
        @(negedge clk);
        chk("t4_ready_after_take", bu.in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);
        chk("t4_next_valid", bu.out_valid, 1);
        chk("t4_next_data", bu.out_data, 8'h11);
        chk("t4_next_count", bu.out_count, 1);
        release_out(0);

        // bubbles with mode toggling mid-frame
        beat(8'd9, 0, 0); gap(2); beat(8'd3, 0, 1); gap(1); beat(8'd7, 1, 0);
        wait_valid();
        chk("t5_data", bu.out_data, 3);
        chk("t5_index", bu.out_index, 1);
        chk("t5_count", bu.out_count, 3);
        release_out(0);

        // reset mid-frame discards it
        beat(8'd50, 0, 1); beat(8'd60, 0, 1);
        pulse_reset();
        gap(3);
        beat(8'd4, 0, 0); beat(8'd2, 1, 0);
        wait_valid();
        chk("t6_data", bu.out_data, 2);
        chk("t6_index", bu.out_index, 1);
        chk("t6_count", bu.out_count, 2);
        release_out(0);

        // counter saturation on the 2-bit instance
        beat(8'd10, 0, 0); beat(8'd20, 0, 0); beat(8'd5, 0, 0); beat(8'd30, 0, 0); beat(8'd1, 1, 0);
        wait_valid();
        chk("t7_model_ovf", e_ovf[2], 1);
        chk("t7_o_data", bo.out_data, 1);
        chk("t7_o_index", bo.out_index, 3);
        chk("t7_o_count", bo.out_count, 3);
        chk("t7_o_ovf", bo.out_ovf, 1);
        chk("t7_u_index", bu.out_index, 4);
        chk("t7_u_ovf", bu.out_ovf, 0);
        release_out(2);

        // random frames, checked cycle by cycle against the model
        for (int f = 0; f < 80; f++) begin
            bit do_rst;
            len    = $urandom_range(1, 7);
            narrow = $urandom_range(0, 1);
            do_rst = ($urandom_range(0, 9) == 0);
            for (int b = 0; b < len; b++) begin
                logic [7:0] v;
                v = narrow ? 8'($urandom_range(0, 3)) : 8'($urandom);
                beat(v, (b == len - 1), 1'($urandom));
                if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 2));
                if (do_rst && b == 0 && len > 1) begin
                    pulse_reset();
                    gap(2);
                    break;
                end
            end
            if (!(do_rst && len > 1)) begin
                wait_valid();
                release_out($urandom_range(0, 3));
            end
        end

        gap(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
